// File: rtl/vp_pattern_gen_if.sv
// Raw video stream bundle: run control and pattern select in, timing/pixel stream and status out.
// The master side is the pattern generator; the slave side is the stream consumer.
interface vp_pattern_gen_if;
    logic        en;
    logic [1:0]  pattern;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        frame_start;
    logic        busy;

    modport master (
        input  en,
        input  pattern,
        output de_out,
        output h_sync_out,
        output v_sync_out,
        output pixel_out,
        output frame_start,
        output busy
    );

    modport slave (
        output en,
        output pattern,
        input  de_out,
        input  h_sync_out,
        input  v_sync_out,
        input  pixel_out,
        input  frame_start,
        input  busy
    );
endinterface

// File: rtl/vp_pattern_gen.sv
// Self-timed video source: programmable raster timing, four test patterns and
// frame-aligned start/stop. All stream outputs are registered one clock after decode.
module vp_pattern_gen #(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    vp_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic [1:0]      r_pat_q;
    logic            r_de;
    logic            r_hs;
    logic            r_vs;
    logic [23:0]     r_pix;
    logic            r_fs;
    logic            r_busy;

    logic [31:0]     w_h32;
    logic [31:0]     w_v32;
    logic            w_de;
    logic            w_hs_act;
    logic            w_vs_act;
    logic            w_last;
    logic            w_origin;
    logic [2:0]      w_bar_idx;
    logic [2:0]      w_chan_off;
    logic [23:0]     w_bar_rgb;
    logic [23:0]     w_pix;

    assign w_h32    = 32'(r_hcnt);
    assign w_v32    = 32'(r_vcnt);
    assign w_de     = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    assign w_hs_act = (w_h32 >= HS_BEG) && (w_h32 < HS_END);
    assign w_vs_act = (w_v32 >= VS_BEG) && (w_v32 < VS_END);
    assign w_last   = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);
    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);

    // Bar order W,Y,C,G,M,R,B,K: R is off when idx[1], G when idx[2], B when idx[0].
    assign w_bar_idx  = 3'(w_h32 / BAR_W);
    assign w_chan_off = {w_bar_idx[1], w_bar_idx[2], w_bar_idx[0]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bar_chan
            assign w_bar_rgb[gi*8 +: 8] = {8{~w_chan_off[gi]}};
        end
    endgenerate

    always_comb begin
        w_pix = 24'h000000;
        case (r_pat_q)
            2'd0:    w_pix = w_bar_rgb;
            2'd1:    w_pix = {3{w_h32[7:0]}};
            2'd2:    w_pix = (w_h32[3] ^ w_v32[3]) ? 24'hFFFFFF : 24'h000000;
            default: w_pix = 24'hFF0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_pat_q <= 2'd0;
            r_de    <= 1'b0;
            r_hs    <= ~SYNC_POL;
            r_vs    <= ~SYNC_POL;
            r_pix   <= 24'h000000;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_hcnt <= '0;
                    r_vcnt <= '0;
                    r_de   <= 1'b0;
                    r_hs   <= ~SYNC_POL;
                    r_vs   <= ~SYNC_POL;
                    r_pix  <= 24'h000000;
                    r_fs   <= 1'b0;
                    r_busy <= vid.en;
                    if (vid.en) begin
                        r_pat_q <= vid.pattern;
                        r_state <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    r_de   <= w_de;
                    r_hs   <= w_hs_act ? SYNC_POL : ~SYNC_POL;
                    r_vs   <= w_vs_act ? SYNC_POL : ~SYNC_POL;
                    r_pix  <= w_de ? w_pix : 24'h000000;
                    r_fs   <= w_origin;
                    // Stays high through the last frame cycle; drops the edge after.
                    r_busy <= 1'b1;
                    if (w_last) begin
                        r_hcnt <= '0;
                        r_vcnt <= '0;
                        if ((r_state == S_RUN) && vid.en) begin
                            r_pat_q <= vid.pattern;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (r_hcnt == H_LAST) begin
                            r_hcnt <= '0;
                            r_vcnt <= r_vcnt + VW'(1);
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                        if ((r_state == S_RUN) && !vid.en) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hcnt  <= '0;
                    r_vcnt  <= '0;
                end
            endcase
        end
    end

    assign vid.de_out      = r_de;
    assign vid.h_sync_out  = r_hs;
    assign vid.v_sync_out  = r_vs;
    assign vid.pixel_out   = r_pix;
    assign vid.frame_start = r_fs;
    assign vid.busy        = r_busy;
endmodule

// File: tb/tb_vp_pattern_gen.sv
// Bench for vp_pattern_gen: frame-position reference model checked every cycle on two
// instances (sync polarity 1 and 0), plus directed checks of the raster and control rules.
module tb_vp_pattern_gen;
    localparam int H_TOTAL = 80;
    localparam int V_TOTAL = 54;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vp_pattern_gen_if vid_p ();
    vp_pattern_gen_if vid_n ();

    vp_pattern_gen #(.SYNC_POL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid_p)
    );

    vp_pattern_gen #(.SYNC_POL(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .vid (vid_n)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // reference model state: whole-frame position rather than separate counters
    bit          m_run   = 1'b0;
    bit          m_drain = 1'b0;
    int          m_pos   = 0;
    int          m_pat   = 0;
    logic        e_de, e_hs, e_vs, e_fs, e_busy;
    logic [23:0] e_pix;

    // observation monitor
    int fs_cnt = 0, last_fs_cyc = 0, fs_gap = 0, fcyc = 0;
    int de_cnt = 0, prev_de = 0, hs_rise = -1, hs_len0 = 0, vs_line = -1, vs_cyc = 0;
    int busy_fall_cyc = -1;
    logic prev_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] ref_pixel(input int pat, input int x, input int y);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (pat)
            0:       return bars[x / 8];
            1:       return {3{8'(x % 256)}};
            2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: return 24'hFF0000;
        endcase
    endfunction

    task automatic set_in(input logic en, input logic [1:0] pat);
        vid_p.en = en;   vid_n.en = en;
        vid_p.pattern = pat; vid_n.pattern = pat;
    endtask

    // Expected outputs after the coming clock edge, given current inputs.
    task automatic model_edge();
        int x, y;
        if (rst) begin
            m_run = 0; m_drain = 0; m_pos = 0; m_pat = 0;
            e_de = 0; e_hs = 0; e_vs = 0; e_pix = '0; e_fs = 0; e_busy = 0;
        end else if (!m_run) begin
            e_de = 0; e_hs = 0; e_vs = 0; e_pix = '0; e_fs = 0;
            e_busy = vid_p.en;
            if (vid_p.en) begin
                m_run = 1; m_drain = 0; m_pos = 0; m_pat = int'(vid_p.pattern);
            end
        end else begin
            x = m_pos % H_TOTAL;
            y = m_pos / H_TOTAL;
            e_de   = (x < 64) && (y < 48);
            e_hs   = (x >= 68) && (x < 76);
            e_vs   = (y >= 50) && (y < 52);
            e_pix  = e_de ? ref_pixel(m_pat, x, y) : 24'h000000;
            e_fs   = (m_pos == 0);
            e_busy = 1'b1;
            if (m_pos == FRAME - 1) begin
                m_pos = 0;
                if (vid_p.en && !m_drain) m_pat = int'(vid_p.pattern);
                else m_run = 0;
            end else begin
                m_pos++;
                if (!vid_p.en) m_drain = 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
        cyc++;
        check_eq("de",     32'(vid_p.de_out),      32'(e_de));
        check_eq("hsync",  32'(vid_p.h_sync_out),  32'(e_hs));
        check_eq("vsync",  32'(vid_p.v_sync_out),  32'(e_vs));
        check_eq("pixel",  32'(vid_p.pixel_out),   32'(e_pix));
        check_eq("fstart", 32'(vid_p.frame_start), 32'(e_fs));
        check_eq("busy",   32'(vid_p.busy),        32'(e_busy));
        check_eq("n_hsync", 32'(vid_n.h_sync_out), 32'(!e_hs));
        check_eq("n_vsync", 32'(vid_n.v_sync_out), 32'(!e_vs));
        check_eq("n_pixel", 32'(vid_n.pixel_out),  32'(e_pix));
        check_eq("n_fstart", 32'(vid_n.frame_start), 32'(e_fs));
        if (vid_p.frame_start === 1'b1) begin
            if (fs_cnt > 0) begin
                prev_de = de_cnt;
                fs_gap  = cyc - last_fs_cyc;
            end
            fs_cnt++;
            last_fs_cyc = cyc;
            fcyc = 0; de_cnt = 0; hs_rise = -1; hs_len0 = 0; vs_line = -1; vs_cyc = 0;
            $display("frame %0d start at cycle %0d pattern %0d", fs_cnt, cyc, vid_p.pattern);
        end else begin
            fcyc++;
        end
        if (vid_p.de_out === 1'b1) de_cnt++;
        if (vid_p.h_sync_out === 1'b1) begin
            if (hs_rise < 0) hs_rise = fcyc;
            if (fcyc < H_TOTAL) hs_len0++;
        end
        if (vid_p.v_sync_out === 1'b1) begin
            if (vs_line < 0) vs_line = fcyc / H_TOTAL;
            vs_cyc++;
        end
        if (prev_busy && vid_p.busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy = vid_p.busy;
    endtask

    // Run until the given frame number / in-frame offset is observed, within a budget.
    task automatic run_to(input string tag, input int tgt_fs, input int tgt_fcyc, input int budget);
        int n = 0;
        while (!(fs_cnt == tgt_fs && fcyc == tgt_fcyc) && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(fs_cnt == tgt_fs && fcyc == tgt_fcyc), 32'd1);
    endtask

    initial begin
        int t0, n;
        set_in(1'b0, 2'd0);
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Two frames of colour bars, then drop en at line 10 of the second frame.
        set_in(1'b1, 2'd0);
        run_to("reach_f1_px0", 1, 0, 10);
        check_eq("bar_px0", 32'(vid_p.pixel_out), 32'hFFFFFF);
        run_to("reach_f1_px8", 1, 8, 20);
        check_eq("bar_px8", 32'(vid_p.pixel_out), 32'hFFFF00);
        run_to("reach_f1_px56", 1, 56, 60);
        check_eq("bar_px56", 32'(vid_p.pixel_out), 32'h000000);
        run_to("reach_f1_blank", 1, 70, 20);
        check_eq("blank_px", 32'(vid_p.pixel_out), 32'h000000);
        run_to("reach_f2_l10", 2, 10 * H_TOTAL, 2 * FRAME);
        check_eq("f2_gap", 32'(fs_gap), 32'(FRAME));
        check_eq("f1_de_cnt", 32'(prev_de), 32'd3072);
        n = 0;
        while (vid_p.busy === 1'b1 && n < 2 * FRAME) begin
            set_in(($urandom_range(0, 9) == 0), 2'($urandom));
            if (fs_cnt == 2 && fcyc > FRAME - 200) set_in(1'b0, 2'($urandom));
            cycle();
            n++;
        end
        set_in(1'b0, 2'd0);
        repeat (20) cycle();
        check_eq("fs_count", 32'(fs_cnt), 32'd2);
        check_eq("f2_de_cnt", 32'(de_cnt), 32'd3072);
        check_eq("hs_offset", 32'(hs_rise), 32'd68);
        check_eq("hs_width", 32'(hs_len0), 32'd8);
        check_eq("vs_line", 32'(vs_line), 32'd50);
        check_eq("vs_cycles", 32'(vs_cyc), 32'd160);
        check_eq("busy_fall", 32'(busy_fall_cyc - last_fs_cyc), 32'(FRAME));

        // Re-raise en with checkerboard; change pattern mid-frame to ramp.
        set_in(1'b1, 2'd2);
        t0 = cyc;
        run_to("restart_fs", 3, 0, 10);
        check_eq("restart_lat", 32'(cyc - t0), 32'd2);
        set_in(1'b1, 2'd1);
        run_to("reach_chk_8_0", 3, 8, 20);
        check_eq("chk_8_0", 32'(vid_p.pixel_out), 32'hFFFFFF);
        run_to("reach_chk_8_8", 3, 8 * H_TOTAL + 8, FRAME);
        check_eq("chk_8_8", 32'(vid_p.pixel_out), 32'h000000);
        run_to("reach_ramp_37", 4, 37, FRAME);
        check_eq("ramp_px37", 32'(vid_p.pixel_out), 32'h252525);
        set_in(1'b1, 2'd3);
        run_to("reach_ramp_l30", 4, 30 * H_TOTAL + 37, FRAME);
        check_eq("ramp_l30_px37", 32'(vid_p.pixel_out), 32'h252525);
        run_to("reach_red_37", 5, 37, FRAME);
        check_eq("red_px37", 32'(vid_p.pixel_out), 32'hFF0000);

        // Asynchronous reset at line 20, then restart.
        run_to("reach_red_l20", 5, 20 * H_TOTAL + 5, FRAME);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_de", 32'(vid_p.de_out), 32'd0);
        check_eq("arst_pix", 32'(vid_p.pixel_out), 32'd0);
        check_eq("arst_hs", 32'(vid_p.h_sync_out), 32'd0);
        check_eq("arst_vs", 32'(vid_p.v_sync_out), 32'd0);
        check_eq("arst_busy", 32'(vid_p.busy), 32'd0);
        check_eq("arst_n_hs", 32'(vid_n.h_sync_out), 32'd1);
        check_eq("arst_n_vs", 32'(vid_n.v_sync_out), 32'd1);
        set_in(1'b1, 2'($urandom));
        repeat (2) cycle();
        rst = 1'b0;
        t0 = cyc;
        run_to("rst_restart_fs", 6, 0, 10);
        check_eq("rst_restart_lat", 32'(cyc - t0), 32'd2);

        // Random run: pattern jitter every cycle, occasional en toggles.
        for (int i = 0; i < 15000; i++) begin
            logic en_v;
            en_v = vid_p.en;
            if ($urandom_range(0, 1999) == 0) en_v = ~en_v;
            set_in(en_v, 2'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
